// File: rtl/filter_pkg.sv
// Shared widths, FSM state type and word popcount for the row filter / BRAM writer chain.
package filter_pkg;

    localparam int unsigned ROW_BITS      = 512;
    localparam int unsigned WORD_BITS     = 32;
    localparam int unsigned WORDS_PER_ROW = 16;
    localparam int unsigned ROW_IDX_W     = 9;
    localparam int unsigned BRAM_ADDR_W   = 13;
    localparam int unsigned WORD_IDX_W    = 4;
    localparam int unsigned POP_W         = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StWrReq,
        StWrWait,
        StDone
    } state_e;

    function automatic logic [5:0] popcount32(input logic [WORD_BITS-1:0] w);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'b0, w[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/conn_neigh_filter_512.sv
// Combinational neighbour filter: keeps a set pixel of row N only if enough of its five
// neighbours (left/right in row N, left/centre/right in row N+1) are set.
module conn_neigh_filter_512
    import filter_pkg::*;
#(
    parameter int unsigned MIN_NEIGH = 1
) (
    input  logic [ROW_BITS-1:0] i_r1,
    input  logic [ROW_BITS-1:0] i_r2,
    output logic [ROW_BITS-1:0] o_out
);

    if (MIN_NEIGH > 5) begin : g_min_neigh_chk
        $error("conn_neigh_filter_512: MIN_NEIGH must be 0..5");
    end

    localparam logic [2:0] MinNb = 3'(MIN_NEIGH);

    // One zero bit on each side so the edges see no neighbour and nothing wraps.
    logic [ROW_BITS+1:0] r1_pad;
    logic [ROW_BITS+1:0] r2_pad;
    logic [2:0]          nb;

    assign r1_pad = {1'b0, i_r1, 1'b0};
    assign r2_pad = {1'b0, i_r2, 1'b0};

    always_comb begin
        o_out = '0;
        nb    = '0;
        for (int i = 0; i < ROW_BITS; i++) begin
            nb = {2'b0, r1_pad[i]} + {2'b0, r1_pad[i+2]} +
                 {2'b0, r2_pad[i]} + {2'b0, r2_pad[i+1]} + {2'b0, r2_pad[i+2]};
            o_out[i] = r1_pad[i+1] && (nb >= MinNb);
        end
    end

endmodule

// File: rtl/row_pair_filter_wr.sv
// Filters row N against rows N/N+1, then writes the result as 16 words to BRAM through the
// write controller, reporting the number of kept pixels.
module row_pair_filter_wr
    import filter_pkg::*;
#(
    parameter int unsigned MIN_NEIGH     = 1,
    parameter int unsigned WORDS_PER_ROW = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_trig,
    output logic                   o_done,
    input  logic [ROW_BITS-1:0]    i_1st_row_512b,
    input  logic [ROW_BITS-1:0]    i_2nd_row_512b,
    input  logic [ROW_IDX_W-1:0]   i_wr_row_num,
    output logic [POP_W-1:0]       o_pop_cnt,
    output logic [BRAM_ADDR_W-1:0] o_wr_to_bram_addr,
    output logic [WORD_BITS-1:0]   o_wr_to_bram_data,
    output logic                   o_wr_to_bram_trig,
    input  logic                   i_wr_to_bram_done
);

    if (WORDS_PER_ROW != filter_pkg::WORDS_PER_ROW) begin : g_words_chk
        $error("row_pair_filter_wr: WORDS_PER_ROW is fixed by the BRAM map");
    end

    localparam logic [WORD_IDX_W-1:0] LastWord = WORD_IDX_W'(WORDS_PER_ROW - 1);

    logic [ROW_BITS-1:0]    filt;
    state_e                 state_q, state_d;
    logic [ROW_BITS-1:0]    row_q, row_d;
    logic [ROW_IDX_W-1:0]   row_num_q, row_num_d;
    logic [WORD_IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [POP_W-1:0]       acc_q, acc_d;
    logic [POP_W-1:0]       pop_q, pop_d;
    logic [BRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_BITS-1:0]   data_q, data_d;
    logic                   trig_q, trig_d;
    logic                   done_pre_q, done_pre_d;

    conn_neigh_filter_512 #(
        .MIN_NEIGH(MIN_NEIGH)
    ) u_filt (
        .i_r1 (i_1st_row_512b),
        .i_r2 (i_2nd_row_512b),
        .o_out(filt)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        row_num_d  = row_num_q;
        word_idx_d = word_idx_q;
        acc_d      = acc_q;
        pop_d      = pop_q;
        addr_d     = addr_q;
        data_d     = data_q;
        trig_d     = trig_q;
        done_pre_d = done_pre_q;
        unique case (state_q)
            StIdle: begin
                done_pre_d = 1'b0;
                trig_d     = 1'b0;
                if (i_trig) state_d = StLatch;
            end
            StLatch: begin
                row_d      = filt;
                row_num_d  = i_wr_row_num;
                word_idx_d = '0;
                acc_d      = '0;
                state_d    = StWrReq;
            end
            StWrReq: begin
                // Controller done must return to zero before the next request.
                if (!i_wr_to_bram_done) begin
                    addr_d  = {row_num_q, word_idx_q};
                    data_d  = row_q[{word_idx_q, 5'b0} +: WORD_BITS];
                    trig_d  = 1'b1;
                    state_d = StWrWait;
                end
            end
            StWrWait: begin
                if (i_wr_to_bram_done) begin
                    trig_d = 1'b0;
                    acc_d  = acc_q + POP_W'(popcount32(data_q));
                    if (word_idx_q == LastWord) begin
                        pop_d      = acc_d;
                        done_pre_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = StWrReq;
                    end
                end
            end
            StDone: begin
                done_pre_d = 1'b1;
                if (!i_trig) begin
                    done_pre_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= StIdle;
            row_q      <= '0;
            row_num_q  <= '0;
            word_idx_q <= '0;
            acc_q      <= '0;
            pop_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            trig_q     <= 1'b0;
            done_pre_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            row_num_q  <= row_num_d;
            word_idx_q <= word_idx_d;
            acc_q      <= acc_d;
            pop_q      <= pop_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            trig_q     <= trig_d;
            done_pre_q <= done_pre_d;
        end
    end

    assign o_done            = done_pre_q & i_trig;
    assign o_pop_cnt         = pop_q;
    assign o_wr_to_bram_addr = addr_q;
    assign o_wr_to_bram_data = data_q;
    assign o_wr_to_bram_trig = trig_q;

endmodule

// File: tb/tb_row_pair_filter_wr.sv
// Bench for row_pair_filter_wr: three instances (MIN_NEIGH 1, 5, 0) share stimulus and are
// checked against a behavioural filter model and a BRAM write-controller responder.
module tb_row_pair_filter_wr;

    localparam int WrLat     = 1;
    localparam int HoldExtra = 3;
    localparam int Budget    = 4000;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         trig = 1'b0;
    logic [511:0] r1 = '0;
    logic [511:0] r2 = '0;
    logic [8:0]   row = '0;

    logic [2:0]  done_o;
    logic [2:0]  wtrig;
    logic [2:0]  wdone = '0;
    logic [9:0]  pop_o [3];
    logic [12:0] addr_o [3];
    logic [31:0] data_o [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned MnG = (g == 0) ? 1 : ((g == 1) ? 5 : 0);
        row_pair_filter_wr #(
            .MIN_NEIGH    (MnG),
            .WORDS_PER_ROW(16)
        ) u_dut (
            .i_clk            (clk),
            .i_rstn           (rstn),
            .i_trig           (trig),
            .o_done           (done_o[g]),
            .i_1st_row_512b   (r1),
            .i_2nd_row_512b   (r2),
            .i_wr_row_num     (row),
            .o_pop_cnt        (pop_o[g]),
            .o_wr_to_bram_addr(addr_o[g]),
            .o_wr_to_bram_data(data_o[g]),
            .o_wr_to_bram_trig(wtrig[g]),
            .i_wr_to_bram_done(wdone[g])
        );
    end

    // Write-controller responder plus capture of every write request.
    logic        clr = 1'b1;
    int          cnt [3] = '{0, 0, 0};
    int          ncap [3] = '{0, 0, 0};
    int          nrise [3] = '{0, 0, 0};
    int          nviol [3] = '{0, 0, 0};
    logic [12:0] cap_a [3][32];
    logic [31:0] cap_d [3][32];
    logic [2:0]  wtrig_prev = '0;
    logic [2:0]  done_prev = '0;

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (wtrig[g] && !wdone[g]) begin
                if (cnt[g] >= WrLat) begin
                    wdone[g] <= 1'b1;
                    cnt[g]   <= 0;
                end else cnt[g] <= cnt[g] + 1;
            end else if (!wtrig[g] && wdone[g]) begin
                if (cnt[g] >= HoldExtra) begin
                    wdone[g] <= 1'b0;
                    cnt[g]   <= 0;
                end else cnt[g] <= cnt[g] + 1;
            end else cnt[g] <= 0;
            if (clr) begin
                ncap[g]  <= 0;
                nrise[g] <= 0;
                nviol[g] <= 0;
            end else begin
                if (wtrig[g] && !wtrig_prev[g]) begin
                    if (ncap[g] < 32) begin
                        cap_a[g][ncap[g]] <= addr_o[g];
                        cap_d[g][ncap[g]] <= data_o[g];
                    end
                    ncap[g] <= ncap[g] + 1;
                    if (wdone[g]) nviol[g] <= nviol[g] + 1;
                end
                if (done_o[g] && !done_prev[g]) nrise[g] <= nrise[g] + 1;
            end
        end
        wtrig_prev <= wtrig;
        done_prev  <= done_o;
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mn_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 5 : 0);
    endfunction

    // Reference: count the five neighbours directly, out-of-range positions count as empty.
    function automatic logic [511:0] model(input logic [511:0] a, input logic [511:0] b,
                                           input int mn);
        logic [511:0] o;
        int nb;
        for (int i = 0; i < 512; i++) begin
            nb = int'(b[i]);
            if (i > 0) nb += int'(a[i-1]) + int'(b[i-1]);
            if (i < 511) nb += int'(a[i+1]) + int'(b[i+1]);
            o[i] = a[i] && (nb >= mn);
        end
        return o;
    endfunction

    function automatic logic [511:0] rand_row();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_caps(input logic [511:0] a, input logic [511:0] b,
                              input logic [8:0] rn, input string tag);
        logic [511:0] e;
        logic [12:0]  ea;
        for (int g = 0; g < 3; g++) begin
            e = model(a, b, mn_of(g));
            check($sformatf("%s_g%0d_nwr", tag, g), ncap[g], 16);
            check($sformatf("%s_g%0d_rtz", tag, g), nviol[g], 0);
            for (int k = 0; k < 16; k++) begin
                ea = 13'(int'(rn) * 16 + k);
                check($sformatf("%s_g%0d_a%0d", tag, g, k), cap_a[g][k], ea);
                check($sformatf("%s_g%0d_d%0d", tag, g, k), cap_d[g][k], e[32*k +: 32]);
            end
            check($sformatf("%s_g%0d_pop", tag, g), pop_o[g], $countones(e));
        end
    endtask

    task automatic start_row(input logic [511:0] a, input logic [511:0] b, input logic [8:0] rn);
        r1  = a;
        r2  = b;
        row = rn;
        clr = 1'b1;
        @(negedge clk);
        clr  = 1'b0;
        trig = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Row data was latched; later input changes must not leak into the write.
        r1  = rand_row();
        r2  = rand_row();
        row = 9'($urandom);
    endtask

    task automatic run_row(input logic [511:0] a, input logic [511:0] b,
                           input logic [8:0] rn, input string tag);
        int t;
        start_row(a, b, rn);
        t = 0;
        while (done_o != 3'b111 && t < Budget) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done"}, done_o, 3'b111);
        check_caps(a, b, rn, tag);
        repeat (12) @(negedge clk);
        for (int g = 0; g < 3; g++) check($sformatf("%s_g%0d_noretrig", tag, g), ncap[g], 16);
        trig = 1'b0;
        @(negedge clk);
        check({tag, "_done_low"}, done_o, 3'b000);
        for (int g = 0; g < 3; g++) check($sformatf("%s_g%0d_done_once", tag, g), nrise[g], 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_g%0d_addr", tag, g), addr_o[g], 0);
            check($sformatf("%s_g%0d_data", tag, g), data_o[g], 0);
            check($sformatf("%s_g%0d_pop", tag, g), pop_o[g], 0);
            check($sformatf("%s_g%0d_wtrig", tag, g), wtrig[g], 0);
            check($sformatf("%s_g%0d_done", tag, g), done_o[g], 0);
        end
    endtask

    initial begin
        logic [511:0] a;
        logic [511:0] b;
        logic [8:0]   rn;
        int           t;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstn = 1'b1;
        clr  = 1'b0;
        repeat (2) @(negedge clk);

        run_row('0, '0, 9'd5, "zero");

        a = '0;
        a[100] = 1'b1;
        run_row(a, '0, 9'd7, "iso");
        b = '0;
        b[100] = 1'b1;
        run_row(a, b, 9'd9, "pair");

        run_row({512{1'b1}}, {512{1'b1}}, 9'd511, "ones");

        a = {64{8'hA5}};
        run_row(a, rand_row(), 9'($urandom), "a5");

        for (int n = 0; n < 3; n++) begin
            run_row(rand_row(), rand_row(), 9'($urandom), $sformatf("rnd%0d", n));
        end
        run_row(rand_row() & rand_row(), rand_row() & rand_row(), 9'($urandom), "sparse");

        // Requester gives up early: the row still completes but done never shows.
        a  = rand_row();
        b  = rand_row();
        rn = 9'($urandom);
        start_row(a, b, rn);
        t = 0;
        while (ncap[0] < 4 && t < Budget) begin
            @(negedge clk);
            t++;
        end
        trig = 1'b0;
        t = 0;
        while ((ncap[0] < 16 || wtrig != 3'b000) && t < Budget) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        check_caps(a, b, rn, "drop");
        for (int g = 0; g < 3; g++) check($sformatf("drop_g%0d_nodone", g), nrise[g], 0);
        run_row(rand_row(), rand_row(), 9'($urandom), "after_drop");

        // Abort mid-row after the 7th handshake.
        start_row(rand_row(), rand_row(), 9'd33);
        t = 0;
        while (!(ncap[0] >= 7 && wdone[0]) && t < Budget) begin
            @(negedge clk);
            t++;
        end
        check("abort_reached7", ncap[0], 7);
        @(negedge clk);
        rstn = 1'b0;
        trig = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        run_row(rand_row(), rand_row(), 9'd33, "rewrite");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
